// File: rtl/tx_scheduler.sv
// Shares one UART transmitter between a status byte source and an atomic 40-byte matrix frame.
// Request to first strobe is 1 cycle, then one byte every 2+ cycles; the transmitter applies backpressure by holding transmit_available low.
module tx_scheduler #(
  parameter int NUMBER_BITS      = 37,
  parameter int BYTES_PER_NUMBER = 5,
  parameter int MATRIX_WORDS     = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [7:0]                          status_byte,
  input  logic                                status_req,
  output logic                                status_ack,
  input  logic [NUMBER_BITS*MATRIX_WORDS-1:0] mtx_data,
  input  logic                                mtx_req,
  output logic                                mtx_ack,
  output logic                                mtx_busy,
  output logic                                mtx_done,
  output logic [7:0]                          transmit_byte,
  input  logic                                transmit_available,
  output logic                                transmit_ready
);

  localparam int MTX_W = NUMBER_BITS * MATRIX_WORDS;
  localparam int WW    = $clog2(MATRIX_WORDS);
  localparam int BW    = $clog2(BYTES_PER_NUMBER);
  localparam logic [WW-1:0] LAST_WORD = WW'(MATRIX_WORDS - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES_PER_NUMBER - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state;
  logic             src_mtx;
  logic [MTX_W-1:0] shadow;
  logic [WW-1:0]    word_idx;
  logic [BW-1:0]    byte_idx;
  logic [WW-1:0]    nxt_word;
  logic [BW-1:0]    nxt_byte;
  logic             frame_last;

  // The top byte of each word carries the leftover bits, zero-padded above.
  function automatic logic [7:0] byte_sel(input logic [MTX_W-1:0] sh,
                                          input logic [WW-1:0] w,
                                          input logic [BW-1:0] b);
    logic [8*BYTES_PER_NUMBER-1:0] padded;
    padded = '0;
    padded[NUMBER_BITS-1:0] = sh[int'(w)*NUMBER_BITS +: NUMBER_BITS];
    return padded[int'(b)*8 +: 8];
  endfunction

  always_comb begin
    frame_last = (word_idx == LAST_WORD) && (byte_idx == LAST_BYTE);
    nxt_byte   = (byte_idx == LAST_BYTE) ? '0 : byte_idx + BW'(1);
    nxt_word   = (byte_idx == LAST_BYTE) ? word_idx + WW'(1) : word_idx;
  end

  assign transmit_ready = (state == S_ISSUE) && transmit_available;
  assign status_ack     = transmit_ready && !src_mtx;
  assign mtx_busy       = src_mtx && (state != S_IDLE);
  assign mtx_done       = (state == S_GAP) && src_mtx && frame_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      src_mtx       <= 1'b0;
      shadow        <= '0;
      word_idx      <= '0;
      byte_idx      <= '0;
      transmit_byte <= 8'h00;
      mtx_ack       <= 1'b0;
    end else begin
      mtx_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (status_req) begin
            transmit_byte <= status_byte;
            src_mtx       <= 1'b0;
            state         <= S_ISSUE;
          end else if (mtx_req) begin
            shadow        <= mtx_data;
            mtx_ack       <= 1'b1;
            word_idx      <= '0;
            byte_idx      <= '0;
            src_mtx       <= 1'b1;
            transmit_byte <= mtx_data[7:0];
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (transmit_available) state <= S_GAP;
        end
        S_GAP: begin
          // Status sources and the final frame byte both end here; a frame never yields mid-way.
          if (!src_mtx || frame_last) begin
            state <= S_IDLE;
          end else begin
            byte_idx      <= nxt_byte;
            word_idx      <= nxt_word;
            transmit_byte <= byte_sel(shadow, nxt_word, nxt_byte);
            state         <= S_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// Randomized bench for tx_scheduler against a queue-based model of the expected UART byte stream.
module tb_tx_scheduler;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   status_byte = 8'h00;
  logic         status_req = 1'b0;
  logic         status_ack;
  logic [295:0] mtx_data = '0;
  logic         mtx_req = 1'b0;
  logic         mtx_ack;
  logic         mtx_busy;
  logic         mtx_done;
  logic [7:0]   transmit_byte;
  logic         transmit_available = 1'b1;
  logic         transmit_ready;

  tx_scheduler dut (
    .clk(clk), .reset(reset),
    .status_byte(status_byte), .status_req(status_req), .status_ack(status_ack),
    .mtx_data(mtx_data), .mtx_req(mtx_req), .mtx_ack(mtx_ack),
    .mtx_busy(mtx_busy), .mtx_done(mtx_done),
    .transmit_byte(transmit_byte), .transmit_available(transmit_available),
    .transmit_ready(transmit_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] dat; bit is_status; bit last; } exp_t;
  exp_t        exp_q[$];
  logic [7:0]  seen[$];
  logic [36:0] mat[8];
  int n_checks = 0, n_err = 0, n_pulse = 0, cyc = 0;
  int uart_hold = 0, busy_left = 0;
  bit done_due = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // UART model: goes unavailable for uart_hold cycles after every strobe.
  always @(posedge clk) begin
    #1;
    if (busy_left > 0) begin
      transmit_available = 1'b0;
      busy_left--;
    end else transmit_available = 1'b1;
  end

  // Monitor: every strobe must match the head of the expected stream.
  always @(negedge clk) begin
    exp_t e;
    check("mtx_done", mtx_done, done_due);
    done_due = 0;
    if (status_ack) check("ack_with_rdy", transmit_ready, 1);
    if (transmit_ready) begin
      n_pulse++;
      busy_left = uart_hold;
      check("rdy_avail", transmit_available, 1);
      check("rdy_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("byte", transmit_byte, e.dat);
        check("status_ack", status_ack, e.is_status);
        if (!e.is_status) seen.push_back(transmit_byte);
        done_due = e.last;
      end
    end
  end

  task automatic push_status(input logic [7:0] b);
    exp_t e;
    e.dat = b; e.is_status = 1; e.last = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_frame();
    exp_t e;
    logic [36:0] w;
    for (int k = 0; k < 40; k++) begin
      w = mat[k / 5] >> (8 * (k % 5));
      e.dat = w[7:0]; e.is_status = 0; e.last = (k == 39);
      exp_q.push_back(e);
    end
  endtask

  task automatic load_mtx();
    for (int k = 0; k < 8; k++) mtx_data[k*37 +: 37] = mat[k];
  endtask

  task automatic rand_mat();
    for (int k = 0; k < 8; k++) mat[k] = 37'({$urandom, $urandom});
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return status_ack;
      1: return mtx_ack;
      2: return mtx_done;
      default: return seen.size() >= 10;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string tag);
    int i;
    i = 0;
    @(negedge clk);
    while (!sig(sel) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check(tag, sig(sel), 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit scramble);
    seen.delete();
    load_mtx();
    push_frame();
    mtx_req = 1'b1;
    wait_for(1, "mtx_ack_seen");
    tick();
    mtx_req = 1'b0;
    if (scramble) mtx_data = {$urandom, $urandom, $urandom, $urandom, $urandom,
                              $urandom, $urandom, $urandom, $urandom, $urandom};
    wait_for(2, "mtx_done_seen");
    tick();
  endtask

  initial begin
    int ack_cyc, p0, mode;
    // Reset held with both requests pending: everything quiet.
    mat = '{37'd24296004000, 37'd0, 37'd24296004001, 37'd0,
            37'd24296004002, 37'd0, 37'(64'd0 - 64'd24296004003), 37'd0};
    load_mtx();
    status_byte = 8'h4B;
    status_req = 1'b1;
    mtx_req = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_byte", transmit_byte, 0);
    check("rst_ready", transmit_ready, 0);
    check("rst_sack", status_ack, 0);
    check("rst_mack", mtx_ack, 0);
    check("rst_busy", mtx_busy, 0);
    check("rst_done", mtx_done, 0);

    // Release: status wins the tie, strobes one cycle later, then the frame follows.
    push_status(8'h4B);
    seen.delete();
    push_frame();
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("idle_no_rdy", transmit_ready, 0);
    @(negedge clk);
    check("first_rdy", transmit_ready, 1);
    check("first_byte", transmit_byte, 8'h4B);
    check("first_sack", status_ack, 1);
    tick();
    status_req = 1'b0;
    @(negedge clk);
    check("rdy_one_cycle", transmit_ready, 0);
    wait_for(1, "tie_mtx_ack");
    tick();
    mtx_req = 1'b0;
    wait_for(2, "tie_done");
    tick();

    // Known frame, UART always free: exact bytes and 2-cycle cadence.
    seen.delete();
    push_frame();
    mtx_req = 1'b1;
    wait_for(1, "t3_ack");
    ack_cyc = cyc;
    check("t3_busy", mtx_busy, 1);
    tick();
    mtx_req = 1'b0;
    wait_for(2, "t3_done");
    check("t3_latency", cyc - ack_cyc, 79);
    check("t3_count", seen.size(), 40);
    check("t3_b0", seen[0], 8'hA0);
    check("t3_b3", seen[3], 8'hA8);
    check("t3_b4", seen[4], 8'h05);
    check("t3_b10", seen[10], 8'hA1);
    check("t3_b30", seen[30], 8'h5D);
    check("t3_b34", seen[34], 8'h1A);
    @(negedge clk);
    check("t3_idle_busy", mtx_busy, 0);
    tick();

    // Slow UART: 7 unavailable cycles after each strobe.
    uart_hold = 7;
    p0 = n_pulse;
    run_frame(1);
    check("t4_pulses", n_pulse - p0, 40);
    check("t4_b34", seen[34], 8'h1A);
    uart_hold = 0;

    // Status raised mid-frame waits for the frame to finish.
    rand_mat();
    seen.delete();
    load_mtx();
    push_frame();
    mtx_req = 1'b1;
    wait_for(1, "t5_ack");
    tick();
    mtx_req = 1'b0;
    wait_for(3, "t5_ten_bytes");
    tick();
    status_byte = 8'hC3;
    push_status(8'hC3);
    status_req = 1'b1;
    wait_for(2, "t5_done");
    wait_for(0, "t5_sack");
    tick();
    status_req = 1'b0;
    tick();

    // Reset mid-frame abandons it; the next frame starts from word 0 byte 0.
    rand_mat();
    seen.delete();
    load_mtx();
    push_frame();
    mtx_req = 1'b1;
    wait_for(1, "t6_ack");
    tick();
    mtx_req = 1'b0;
    wait_for(3, "t6_ten_bytes");
    tick();
    reset = 1'b0;
    #1;
    check("t6_rdy", transmit_ready, 0);
    check("t6_byte", transmit_byte, 0);
    check("t6_busy", mtx_busy, 0);
    exp_q.delete();
    repeat (3) tick();
    reset = 1'b1;
    repeat (20) tick();
    check("t6_idle_busy", mtx_busy, 0);
    rand_mat();
    run_frame(0);
    check("t6_restart_b0", seen[0], {1'b0, mat[0][7:0]});
    check("t6_restart_b4", seen[4], {3'b000, mat[0][36:32]});

    // Random mix of status bytes and frames under varying UART speed.
    for (int it = 0; it < 8; it++) begin
      uart_hold = $urandom_range(0, 3);
      mode = $urandom_range(0, 2);
      rand_mat();
      status_byte = 8'($urandom);
      if (mode == 0) begin
        push_status(status_byte);
        status_req = 1'b1;
        wait_for(0, "rnd_sack");
        tick();
        status_req = 1'b0;
        tick();
      end else if (mode == 1) begin
        run_frame(1);
      end else begin
        push_status(status_byte);
        seen.delete();
        load_mtx();
        push_frame();
        status_req = 1'b1;
        mtx_req = 1'b1;
        wait_for(0, "rnd_tie_sack");
        tick();
        status_req = 1'b0;
        wait_for(1, "rnd_tie_mack");
        tick();
        mtx_req = 1'b0;
        wait_for(2, "rnd_tie_done");
        tick();
      end
    end
    repeat (10) tick();
    check("exp_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
